hex_print: RTL
==============

# hex_print

Upstream formatter for the UART transmit path. It accepts a binary value with a one-cycle request pulse and renders it as uppercase ASCII hex followed by CR LF. It emits the characters one byte at a time into the UART transmitter's byte-enqueue interface (`tx_start`/`tx_data`/`tx_ready`). It paces strobes so the transmitter's registered `ready` flag, which lags by one cycle, can never cause a dropped byte.

## Interface
- `NIBBLES`, default 8: number of hex digits printed; legal range 1..16; value width is 4*NIBBLES.
- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `print_start` input 1: one-cycle request; sampled only while `busy`=0.
- `value` input 4*NIBBLES: number to print; captured on the accepting edge.
- `tx_ready` input 1: transmitter can accept a byte (driven by the transmitter's `ready`).
- `tx_start` output 1: one-cycle byte strobe to the transmitter (drives its `start_uart`).
- `tx_data` output 8: ASCII byte; valid while `tx_start`=1.
- `busy` output 1: request in progress; new requests are ignored.
- `done` output 1: one-cycle pulse when a request has fully completed.

## Operation
- Reset values: `tx_start`=0, `tx_data`=8'h00, `busy`=0, `done`=0. State is IDLE, holdoff counter is 0, and the captured value is 0.
- States: IDLE -> PFX0 -> PFX1 -> DIGIT -> CR -> LF -> FINISH -> IDLE. PFX0/PFX1 exist only with the macro described under Configuration.
- IDLE: on `print_start`=1, capture `value`, load the nibble index with NIBBLES-1, set `busy`=1, and go to the first emitting state.
- Each emitting state issues exactly one strobe, then advances:
  - PFX0 emits 8'h30 ('0').
  - PFX1 emits 8'h78 ('x').
  - DIGIT emits the nibble at the index (MSB first). The index decrements after each digit; leave DIGIT after the strobe at index 0.
  - CR emits 8'h0D.
  - LF emits 8'h0A.
- Nibble encoding: 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10), uppercase only.
- FINISH: wait out the holdoff, then pulse `done`=1, set `busy`=0, and return to IDLE.
- `print_start` while `busy`=1 is ignored, with no queuing. `print_start` in the same cycle as `done`=1 is accepted, because `busy` is already 0.
- The captured value is held for the whole request; changes on `value` while busy have no effect.
- `tx_data` holds its last byte when `tx_start`=0.
- Reset asserted mid-request: all registers clear immediately, `tx_start` drops asynchronously, and the remaining characters are discarded. A partial line in the transmitter FIFO is not recalled.

## Timing
- `tx_start` and `tx_data` are registered. A strobe is registered at edge k only if, in the cycle ending at k:
  - an emitting state is active,
  - the holdoff counter is 0, and
  - `tx_ready`=1.
- Holdoff: after a strobe in cycle N, `tx_ready` is ignored in cycles N and N+1. Minimum strobe spacing is therefore 3 cycles (N, N+3, ...). This covers the transmitter's one-cycle-stale `ready`.
- With `tx_ready` held high, a request sampled at the edge ending cycle 0 gives:
  - first strobe in cycle 3,
  - subsequent strobes every 3 cycles,
  - LF strobe in cycle 3*B, where B is the bytes per line,
  - `done` pulse and `busy`=0 in cycle 3*B+3.
- `busy` rises in cycle 1.
- `tx_ready` low stalls the current state indefinitely with no timeout. The strobe resumes at the cycle after the first high sample (holdoff permitting).
- Bytes per line B = NIBBLES+2, or NIBBLES+4 with the prefix. The nibble index is 4 bits wide; no wrap beyond NIBBLES-1.

## Configuration
- `HEX_PRINT_PREFIX_EN` defined: PFX0/PFX1 are compiled in, and every line starts with "0x"; B = NIBBLES+4.
- Not defined: those states and their logic are absent; IDLE goes directly to DIGIT; B = NIBBLES+2.

## Test plan
- Prefix on, NIBBLES=8, `tx_ready`=1, `value`=32'h1234ABCD -> bytes 30 78 31 32 33 34 41 42 43 44 0D 0A, strobes exactly 3 cycles apart, `done` single pulse 3 cycles after the LF strobe.
- Prefix off, `value`=32'h0000F00A -> 30 30 30 30 46 30 30 41 0D 0A (10 bytes), no 30 78 lead.
- Drop `tx_ready` for 50 cycles after the 3rd digit -> no `tx_start` during the stall, sequence resumes with the 4th digit, no byte skipped or repeated.
- Pulse `print_start` with `value`=32'hFFFFFFFF mid-request -> ignored, current line completes unchanged; a new pulse in the `done` cycle is accepted and prints immediately after.
- Assert `rst_n`=0 during DIGIT -> `tx_start`=0, `busy`=0, `done`=0, `tx_data`=00 immediately; after release, a new request prints a full correct line from its first character.
- NIBBLES=2, prefix on, `value`=8'hF0 -> 30 78 46 30 0D 0A.

Source files
------------

// File: rtl/hex_print_if.sv
// hex_print request and transmitter byte-enqueue bundle.
// slave = formatter side, master = requester/transmitter side.
interface hex_print_if #(
  parameter int NIBBLES = 8
);
  logic                   print_start;
  logic [4*NIBBLES-1:0]   value;
  logic                   tx_ready;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   busy;
  logic                   done;

  modport slave (
    input  print_start,
    input  value,
    input  tx_ready,
    output tx_start,
    output tx_data,
    output busy,
    output done
  );

  modport master (
    output print_start,
    output value,
    output tx_ready,
    input  tx_start,
    input  tx_data,
    input  busy,
    input  done
  );
endinterface

// File: rtl/hex_print.sv
// Renders a value as uppercase ASCII hex + CR LF into a UART byte queue.
// Define HEX_PRINT_PREFIX_EN to start every line with "0x".
module hex_print #(
  parameter int NIBBLES = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  hex_print_if.slave bus
);

  localparam int W = 4 * NIBBLES;

  typedef enum logic [2:0] {
    IDLE,
`ifdef HEX_PRINT_PREFIX_EN
    PFX0,
    PFX1,
`endif
    DIGIT,
    CR,
    LF,
    FINISH
  } state_t;

  state_t         state_q;
  state_t         next_d;
  logic [W-1:0]   value_q;
  logic [3:0]     idx_q;
  logic [1:0]     hold_q;
  logic           tx_start_q;
  logic [7:0]     tx_data_q;
  logic           busy_q;
  logic           done_q;
  logic [3:0]     nib_d;
  logic [7:0]     hex_d;
  logic [7:0]     byte_d;

  // Select the nibble addressed by the index, MSB first.
  always_comb begin
    nib_d = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == 4'(i)) nib_d = value_q[4*i +: 4];
    end
  end

  // Nibble to uppercase ASCII hex.
  always_comb begin
    hex_d = 8'h00;
    unique case (1'b1)
      (nib_d < 4'd10): hex_d = 8'h30 + {4'h0, nib_d};
      default:         hex_d = 8'h37 + {4'h0, nib_d};
    endcase
  end

  // Byte to emit and the state that follows the strobe.
  always_comb begin
    byte_d = 8'h00;
    next_d = state_q;
    unique case (state_q)
`ifdef HEX_PRINT_PREFIX_EN
      PFX0: begin
        byte_d = 8'h30;
        next_d = PFX1;
      end
      PFX1: begin
        byte_d = 8'h78;
        next_d = DIGIT;
      end
`endif
      DIGIT: begin
        byte_d = hex_d;
        next_d = (idx_q == 4'd0) ? CR : DIGIT;
      end
      CR: begin
        byte_d = 8'h0D;
        next_d = LF;
      end
      LF: begin
        byte_d = 8'h0A;
        next_d = FINISH;
      end
      default: begin
        byte_d = 8'h00;
        next_d = state_q;
      end
    endcase
  end

  // Sequencer: accept, pace strobes with a 2-cycle holdoff, finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      value_q    <= '0;
      idx_q      <= 4'd0;
      hold_q     <= 2'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (hold_q != 2'd0) hold_q <= hold_q - 2'd1;
      unique case (state_q)
        IDLE: begin
          if (bus.print_start) begin
            value_q <= bus.value;
            idx_q   <= 4'(NIBBLES - 1);
            busy_q  <= 1'b1;
            // One idle cycle so the first strobe lands in cycle 3.
            hold_q  <= 2'd1;
`ifdef HEX_PRINT_PREFIX_EN
            state_q <= PFX0;
`else
            state_q <= DIGIT;
`endif
          end
        end
        FINISH: begin
          if (hold_q == 2'd0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          if (hold_q == 2'd0 && bus.tx_ready) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= byte_d;
            // Ignore ready in the strobe cycle and the next one.
            hold_q     <= 2'd2;
            state_q    <= next_d;
            if (state_q == DIGIT && idx_q != 4'd0)
              idx_q <= idx_q - 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
